// File: rtl/cmd_trace_mon.sv
// Retired-instruction trace monitor: decodes qualified commands into a show-ahead FIFO.
// Define CMD_TRACE_TS_EN to add a free-running timestamp stored with each entry (rd_ts).
module cmd_trace_mon #(
  parameter int CMD_W = 24,
  parameter int OP_W  = 6,
  parameter int REG_W = 5,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_vld,
  input  logic [CMD_W-1:0]              cmd,
  input  logic                          filt_en,
  input  logic [OP_W-1:0]               filt_op,
  input  logic                          clr,
  input  logic                          rd_rdy,
  output logic                          rd_vld,
  output logic [OP_W-1:0]               rd_op,
  output logic [REG_W-1:0]              rd_des,
  output logic [REG_W-1:0]              rd_src,
  output logic [CMD_W-OP_W-2*REG_W-1:0] rd_imm,
  output logic [$clog2(DEPTH):0]        cnt,
  output logic [15:0]                   ovf_cnt
`ifdef CMD_TRACE_TS_EN
  ,
  output logic [TS_W-1:0]               rd_ts
`endif
);

  localparam int IMM_W = CMD_W - OP_W - 2*REG_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  if (IMM_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
    $error("cmd_trace_mon: illegal parameter combination");
  end

  // Field order matches the instruction word, so a command casts straight to an entry.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] des;
    logic [REG_W-1:0] src;
    logic [IMM_W-1:0] imm;
  } ent_t;

  ent_t          cin;
  ent_t          head;
  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          qual, full, push, pop, drop;

  always_comb begin
    cin    = ent_t'(cmd);
    qual   = cmd_vld && (!filt_en || cin.op == filt_op);
    full   = (cnt_q == CW'(DEPTH));
    pop    = (cnt_q != '0) && rd_rdy;
    push   = qual && (!full || pop);
    drop   = qual && full && !pop;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is left unreset; the read mux zeroes the fields whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q] <= cin;
  end

  always_comb begin
    rd_vld  = (cnt_q != '0);
    head    = rd_vld ? mem_q[rptr_q] : '0;
    rd_op   = head.op;
    rd_des  = head.des;
    rd_src  = head.src;
    rd_imm  = head.imm;
    cnt     = cnt_q;
    ovf_cnt = ovf_q;
  end

`ifdef CMD_TRACE_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] ts_mem_q [DEPTH];

  always_comb ts_d = ts_q + TS_W'(1);

  // Free-running; deliberately untouched by clr so timestamps stay monotonic across flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  always_ff @(posedge clk) begin
    if (push && !clr) ts_mem_q[wptr_q] <= ts_q;
  end

  always_comb rd_ts = rd_vld ? ts_mem_q[rptr_q] : '0;
`endif

endmodule

// File: tb/tb_cmd_trace_mon.sv
// Directed bench for cmd_trace_mon: decode, overflow, full push+pop, filter, clr, reset, timestamp.
module tb_cmd_trace_mon;
  localparam int CMD_W = 24;
  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;

  logic             clk, rst_n, cmd_vld, filt_en, clr, rd_rdy, rd_vld;
  logic [CMD_W-1:0] cmd;
  logic [OP_W-1:0]  filt_op, rd_op;
  logic [REG_W-1:0] rd_des, rd_src;
  logic [7:0]       rd_imm;
  logic [3:0]       cnt;
  logic [15:0]      ovf_cnt;
`ifdef CMD_TRACE_TS_EN
  logic [TS_W-1:0]  rd_ts;
`endif

  cmd_trace_mon #(.CMD_W(CMD_W), .OP_W(OP_W), .REG_W(REG_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(cmd), .filt_en(filt_en),
    .filt_op(filt_op), .clr(clr), .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_op(rd_op),
    .rd_des(rd_des), .rd_src(rd_src), .rd_imm(rd_imm), .cnt(cnt), .ovf_cnt(ovf_cnt)
`ifdef CMD_TRACE_TS_EN
    , .rd_ts(rd_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mk(input logic [5:0] op, input logic [4:0] des,
                                     input logic [4:0] src, input logic [7:0] imm);
    return {op, des, src, imm};
  endfunction

  task automatic cap(input logic [23:0] c);
    cmd_vld = 1'b1;
    cmd     = c;
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic pop1();
    rd_rdy = 1'b1;
    step();
    rd_rdy = 1'b0;
  endtask

  logic [5:0] fops [6];
  logic [7:0] exp_imm;

  initial begin
    rst_n = 1'b0; cmd_vld = 1'b0; cmd = '0; filt_en = 1'b0; filt_op = 6'h03;
    clr = 1'b0; rd_rdy = 1'b0;
    #12;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_vld", 32'(rd_vld), 32'd0);
    chk("rst_op", 32'(rd_op), 32'd0);
    chk("rst_imm", 32'(rd_imm), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Decode; filt_op is ignored because filt_en is low
    cmd_vld = 1'b1; cmd = 24'hA51234;
    chk("dec_vld_pre", 32'(rd_vld), 32'd0);
    step();
    cmd_vld = 1'b0;
    chk("dec_vld", 32'(rd_vld), 32'd1);
    chk("dec_op", 32'(rd_op), 32'h29);
    chk("dec_des", 32'(rd_des), 32'h08);
    chk("dec_src", 32'(rd_src), 32'h12);
    chk("dec_imm", 32'(rd_imm), 32'h34);
    pop1();
    chk("dec_cnt", 32'(cnt), 32'd0);

    // Overflow: 10 captures into 8 entries
    for (int i = 0; i < 10; i++) cap(mk(6'h10, 5'd1, 5'd2, 8'(i)));
    chk("ovf_cnt_full", 32'(cnt), 32'd8);
    chk("ovf_drops", 32'(ovf_cnt), 32'd2);
    step();
    chk("hold_imm", 32'(rd_imm), 32'd0);
    chk("hold_cnt", 32'(cnt), 32'd8);

    // Push and pop together while full
    cmd_vld = 1'b1; cmd = mk(6'h11, 5'd3, 5'd4, 8'h55); rd_rdy = 1'b1;
    step();
    cmd_vld = 1'b0; rd_rdy = 1'b0;
    chk("pp_cnt", 32'(cnt), 32'd8);
    chk("pp_ovf", 32'(ovf_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      exp_imm = (i < 7) ? 8'(i + 1) : 8'h55;
      chk($sformatf("drain_imm%0d", i), 32'(rd_imm), 32'(exp_imm));
      pop1();
    end
    chk("drain_cnt", 32'(cnt), 32'd0);
    chk("drain_vld", 32'(rd_vld), 32'd0);

    // Filter: two of six opcodes match
    fops[0] = 6'h0C; fops[1] = 6'h01; fops[2] = 6'h0C;
    fops[3] = 6'h3F; fops[4] = 6'h02; fops[5] = 6'h0D;
    filt_en = 1'b1; filt_op = 6'h0C;
    for (int k = 0; k < 6; k++) cap(mk(fops[k], 5'd0, 5'd0, 8'(k + 32'h20)));
    filt_en = 1'b0;
    chk("filt_cnt", 32'(cnt), 32'd2);
    chk("filt_op0", 32'(rd_op), 32'h0C);
    chk("filt_imm0", 32'(rd_imm), 32'h20);
    pop1();
    chk("filt_op1", 32'(rd_op), 32'h0C);
    chk("filt_imm1", 32'(rd_imm), 32'h22);
    pop1();
    chk("filt_empty", 32'(cnt), 32'd0);

    // clr beats a same-cycle capture and pop
    for (int i = 0; i < 5; i++) cap(mk(6'h15, 5'd0, 5'd0, 8'(i)));
    chk("clr_pre_cnt", 32'(cnt), 32'd5);
    clr = 1'b1; cmd_vld = 1'b1; cmd = mk(6'h15, 5'd0, 5'd0, 8'hEE); rd_rdy = 1'b1;
    step();
    clr = 1'b0; cmd_vld = 1'b0; rd_rdy = 1'b0;
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_ovf", 32'(ovf_cnt), 32'd0);
    chk("clr_vld", 32'(rd_vld), 32'd0);
    cap(mk(6'h16, 5'd0, 5'd0, 8'h66));
    chk("post_clr_imm", 32'(rd_imm), 32'h66);
    pop1();

    // Asynchronous reset mid-stream, checked before the next clock edge
    for (int i = 0; i < 10; i++) cap(mk(6'h17, 5'd0, 5'd0, 8'(i + 32'h40)));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_ovf", 32'(ovf_cnt), 32'd0);
    chk("arst_vld", 32'(rd_vld), 32'd0);
    chk("arst_op", 32'(rd_op), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap(mk(6'h2A, 5'd1, 5'd1, 8'h77));
    chk("post_rst_cnt", 32'(cnt), 32'd1);
    chk("post_rst_op", 32'(rd_op), 32'h2A);
    chk("post_rst_imm", 32'(rd_imm), 32'h77);
    pop1();

`ifdef CMD_TRACE_TS_EN
    // Counter is 0 through the first edge after release; captures land at values 3 and 7
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    cap(mk(6'h01, 5'd0, 5'd0, 8'h01));
    step(); step(); step();
    cap(mk(6'h02, 5'd0, 5'd0, 8'h02));
    chk("ts0", 32'(rd_ts), 32'd3);
    pop1();
    chk("ts1", 32'(rd_ts), 32'd7);
    pop1();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
